// File: rtl/buffer_drain_ctrl_pkg.sv
// Package: buffer_pkg
// Shared constants and types for the read side of the 12-entry counter
// buffer: capacity, drain period, level/timer widths and the drain FSM
// state encoding.
package buffer_pkg;

    localparam int DEPTH  = 12;
    localparam int PERIOD = 28;
    localparam int LW     = 4;
    localparam int TW     = 5;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        OFFER
    } drain_state_t;

    typedef logic [LW-1:0] level_t;
    typedef logic [TW-1:0] timer_t;

endpackage

// File: rtl/buffer_drain_ctrl_if.sv
// Interface: buffer_drain_ctrl_if
// Groups the producer write strobe and the downstream valid/ready handshake.
//   wr_en    : producer pushed one entry this cycle
//   rd_valid : an entry is offered to downstream
//   rd_ready : downstream accepts the offered entry
// The master modport is the drain controller; the slave modport is its
// environment (producer strobe plus downstream consumer).
interface buffer_drain_ctrl_if;

    logic wr_en;
    logic rd_valid;
    logic rd_ready;

    modport master (
        input  wr_en,
        input  rd_ready,
        output rd_valid
    );

    modport slave (
        output wr_en,
        output rd_ready,
        input  rd_valid
    );

endinterface

// File: rtl/buffer_drain_ctrl_timer.sv
// Module: period_timer
// Wrap counter that runs while enable is high and holds otherwise.
// Counts 0..PERIOD-1; tick flags the last count of a period while enabled.
//   clk    : clock, posedge
//   reset  : synchronous, active-high
//   enable : count enable
//   timer  : current count
//   tick   : enable && timer == PERIOD-1 (combinational)
module period_timer #(
    parameter int PERIOD = 28,
    parameter int TW     = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    output logic [TW-1:0] timer,
    output logic          tick
);

    localparam logic [TW-1:0] LAST = TW'(PERIOD - 1);

    assign tick = enable && (timer == LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            timer <= '0;
        end else if (enable) begin
            if (timer == LAST) begin
                timer <= '0;
            end else begin
                timer <= timer + 1'b1;
            end
        end
    end

endmodule

// File: rtl/buffer_drain_ctrl.sv
// Module: buffer_drain_ctrl
// Consumer side of the counter buffer. Tracks occupancy from producer write
// strobes and drains one entry per timer period over a valid/ready handshake.
//   clk      : clock, posedge
//   reset    : synchronous, active-high, overrides every other input
//   enable   : gates the period timer and new read offers
//   bus      : wr_en / rd_valid / rd_ready (master modport)
//   level    : occupancy 0..DEPTH
//   timer    : drain period timer 0..PERIOD-1
//   full     : level == DEPTH
//   empty    : level == 0
//   overflow : sticky, a write was dropped because the buffer was full
module buffer_drain_ctrl
    import buffer_pkg::*;
#(
    parameter int DEPTH_P  = DEPTH,
    parameter int PERIOD_P = PERIOD
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    buffer_drain_ctrl_if.master        bus,
    output level_t                     level,
    output timer_t                     timer,
    output logic                       full,
    output logic                       empty,
    output logic                       overflow
);

    localparam level_t FULL_LEVEL = LW'(DEPTH_P);

    drain_state_t state;
    drain_state_t state_next;
    level_t       level_next;
    logic         tick;
    logic         pop;
    logic         push;

    period_timer #(
        .PERIOD (PERIOD_P),
        .TW     (TW)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .timer  (timer),
        .tick   (tick)
    );

    assign full  = (level == FULL_LEVEL);
    assign empty = (level == '0);

    // rd_valid comes straight from the state flop, so it is registered and
    // cannot be withdrawn until the FSM leaves OFFER on a pop.
    assign bus.rd_valid = (state == OFFER);

    assign pop  = bus.rd_valid && bus.rd_ready;
    // A pop in the same cycle frees the slot, so a write into a full buffer
    // is still accepted then.
    assign push = bus.wr_en && (!full || pop);

    always_comb begin
        level_next = level;
        if (push && !pop) begin
            level_next = level + 1'b1;
        end else if (pop && !push) begin
            level_next = level - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            level <= level_next;
            if (bus.wr_en && full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // OFFER is only entered from WAIT with a non-empty buffer, and the
    // offered entry stays counted in level, so a pop can never underflow.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (enable && !empty) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (!enable || empty) begin
                    state_next = IDLE;
                end else if (tick) begin
                    state_next = OFFER;
                end
            end
            OFFER: begin
                if (pop) begin
                    if (enable && (level_next != '0)) begin
                        state_next = WAIT;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_buffer_drain_ctrl.sv
// Testbench: tb_buffer_drain_ctrl
// Directed scenarios for buffer_drain_ctrl with hand-computed expectations.
module tb_buffer_drain_ctrl;

    logic       clk;
    logic       reset;
    logic       enable;
    logic [3:0] level;
    logic [4:0] timer;
    logic       full;
    logic       empty;
    logic       overflow;

    int checks;
    int errors;

    buffer_drain_ctrl_if bus ();

    buffer_drain_ctrl dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .bus      (bus.master),
        .level    (level),
        .timer    (timer),
        .full     (full),
        .empty    (empty),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        enable       = 1'b0;
        bus.wr_en    = 1'b0;
        bus.rd_ready = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    // Step until rd_valid rises or the budget runs out; n is edges taken.
    task automatic wait_valid(input int limit, output int n);
        n = 0;
        while (bus.rd_valid !== 1'b1 && n < limit) begin
            step();
            n++;
        end
    endtask

    task automatic write_n(input int count);
        for (int i = 0; i < count; i++) begin
            bus.wr_en = 1'b1;
            step();
        end
        bus.wr_en = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks += 6;
        if (level !== 4'd0) begin errors++; $display("[TB] FAIL reset.level got %0d want 0", level); end
        if (timer !== 5'd0) begin errors++; $display("[TB] FAIL reset.timer got %0d want 0", timer); end
        if (bus.rd_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset.rd_valid got %b want 0", bus.rd_valid); end
        if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL reset.overflow got %b want 0", overflow); end
        if (full !== 1'b0) begin errors++; $display("[TB] FAIL reset.full got %b want 0", full); end
        if (empty !== 1'b1) begin errors++; $display("[TB] FAIL reset.empty got %b want 1", empty); end
    endtask

    task automatic test_drain();
        logic [3:0] exp_level;
        logic [4:0] exp_timer;
        logic       exp_valid;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            bus.wr_en = 1'b1;
            step();
            bus.wr_en = 1'b0;
            step();
        end
        checks += 2;
        if (level !== 4'd3) begin errors++; $display("[TB] FAIL drain.fill_level got %0d want 3", level); end
        if (timer !== 5'd0) begin errors++; $display("[TB] FAIL drain.fill_timer got %0d want 0", timer); end
        enable       = 1'b1;
        bus.rd_ready = 1'b1;
        // Offers land after edges 28, 56 and 84; each pops on the next edge.
        for (int k = 1; k <= 90; k++) begin
            step();
            exp_valid = (k == 28) || (k == 56) || (k == 84);
            exp_level = (k < 29) ? 4'd3 : (k < 57) ? 4'd2 : (k < 85) ? 4'd1 : 4'd0;
            exp_timer = 5'(k % 28);
            checks += 3;
            if (bus.rd_valid !== exp_valid) begin errors++; $display("[TB] FAIL drain.rd_valid cycle %0d got %b want %b", k, bus.rd_valid, exp_valid); end
            if (level !== exp_level) begin errors++; $display("[TB] FAIL drain.level cycle %0d got %0d want %0d", k, level, exp_level); end
            if (timer !== exp_timer) begin errors++; $display("[TB] FAIL drain.timer cycle %0d got %0d want %0d", k, timer, exp_timer); end
        end
        checks++;
        if (empty !== 1'b1) begin errors++; $display("[TB] FAIL drain.empty got %b want 1", empty); end
        enable       = 1'b0;
        bus.rd_ready = 1'b0;
    endtask

    task automatic test_overflow();
        logic [3:0] exp_level;
        do_reset();
        for (int k = 1; k <= 14; k++) begin
            bus.wr_en = 1'b1;
            step();
            exp_level = (k > 12) ? 4'd12 : 4'(k);
            checks += 4;
            if (level !== exp_level) begin errors++; $display("[TB] FAIL ovf.level write %0d got %0d want %0d", k, level, exp_level); end
            if (full !== (k >= 12)) begin errors++; $display("[TB] FAIL ovf.full write %0d got %b want %b", k, full, (k >= 12)); end
            if (overflow !== (k >= 13)) begin errors++; $display("[TB] FAIL ovf.overflow write %0d got %b want %b", k, overflow, (k >= 13)); end
            if (timer !== 5'd0) begin errors++; $display("[TB] FAIL ovf.timer write %0d got %0d want 0", k, timer); end
        end
        bus.wr_en = 1'b0;
        step();
        checks++;
        if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL ovf.sticky got %b want 1", overflow); end
        do_reset();
        checks++;
        if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL ovf.cleared got %b want 0", overflow); end
    endtask

    task automatic test_full_pop_push();
        int n;
        do_reset();
        write_n(12);
        checks += 2;
        if (full !== 1'b1) begin errors++; $display("[TB] FAIL fpp.full got %b want 1", full); end
        if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL fpp.pre_overflow got %b want 0", overflow); end
        enable = 1'b1;
        wait_valid(40, n);
        checks++;
        if (n !== 28) begin errors++; $display("[TB] FAIL fpp.offer_latency got %0d want 28", n); end
        bus.rd_ready = 1'b1;
        bus.wr_en    = 1'b1;
        step();
        bus.rd_ready = 1'b0;
        bus.wr_en    = 1'b0;
        checks += 4;
        if (level !== 4'd12) begin errors++; $display("[TB] FAIL fpp.level got %0d want 12", level); end
        if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL fpp.overflow got %b want 0", overflow); end
        if (full !== 1'b1) begin errors++; $display("[TB] FAIL fpp.full_after got %b want 1", full); end
        if (bus.rd_valid !== 1'b0) begin errors++; $display("[TB] FAIL fpp.rd_valid got %b want 0", bus.rd_valid); end
        enable = 1'b0;
    endtask

    task automatic test_hold();
        int n;
        do_reset();
        write_n(5);
        enable = 1'b1;
        wait_valid(40, n);
        checks++;
        if (n !== 28) begin errors++; $display("[TB] FAIL hold.offer_latency got %0d want 28", n); end
        for (int i = 0; i < 40; i++) begin
            if (i == 20) enable = 1'b0;
            step();
            checks += 2;
            if (bus.rd_valid !== 1'b1) begin errors++; $display("[TB] FAIL hold.rd_valid cycle %0d got %b want 1", i, bus.rd_valid); end
            if (level !== 4'd5) begin errors++; $display("[TB] FAIL hold.level cycle %0d got %0d want 5", i, level); end
        end
        checks++;
        if (timer !== 5'd20) begin errors++; $display("[TB] FAIL hold.timer got %0d want 20", timer); end
        bus.rd_ready = 1'b1;
        step();
        bus.rd_ready = 1'b0;
        checks += 2;
        if (level !== 4'd4) begin errors++; $display("[TB] FAIL hold.pop_level got %0d want 4", level); end
        if (bus.rd_valid !== 1'b0) begin errors++; $display("[TB] FAIL hold.pop_valid got %b want 0", bus.rd_valid); end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (bus.rd_valid !== 1'b0) begin errors++; $display("[TB] FAIL hold.idle_valid cycle %0d got %b want 0", i, bus.rd_valid); end
        end
    endtask

    task automatic test_reset_in_offer();
        int n;
        do_reset();
        write_n(5);
        enable = 1'b1;
        wait_valid(40, n);
        checks += 2;
        if (n !== 28) begin errors++; $display("[TB] FAIL rio.offer_latency got %0d want 28", n); end
        if (level !== 4'd5) begin errors++; $display("[TB] FAIL rio.level_before got %0d want 5", level); end
        reset        = 1'b1;
        bus.wr_en    = 1'b1;
        bus.rd_ready = 1'b1;
        step();
        reset        = 1'b0;
        bus.wr_en    = 1'b0;
        bus.rd_ready = 1'b0;
        enable       = 1'b0;
        checks += 6;
        if (level !== 4'd0) begin errors++; $display("[TB] FAIL rio.level got %0d want 0", level); end
        if (timer !== 5'd0) begin errors++; $display("[TB] FAIL rio.timer got %0d want 0", timer); end
        if (bus.rd_valid !== 1'b0) begin errors++; $display("[TB] FAIL rio.rd_valid got %b want 0", bus.rd_valid); end
        if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL rio.overflow got %b want 0", overflow); end
        if (empty !== 1'b1) begin errors++; $display("[TB] FAIL rio.empty got %b want 1", empty); end
        if (full !== 1'b0) begin errors++; $display("[TB] FAIL rio.full got %b want 0", full); end
    endtask

    task automatic test_wrap();
        logic [4:0] exp_timer;
        do_reset();
        enable = 1'b1;
        for (int k = 1; k <= 56; k++) begin
            step();
            exp_timer = 5'(k % 28);
            checks += 3;
            if (timer !== exp_timer) begin errors++; $display("[TB] FAIL wrap.timer cycle %0d got %0d want %0d", k, timer, exp_timer); end
            if (bus.rd_valid !== 1'b0) begin errors++; $display("[TB] FAIL wrap.rd_valid cycle %0d got %b want 0", k, bus.rd_valid); end
            if (level !== 4'd0) begin errors++; $display("[TB] FAIL wrap.level cycle %0d got %0d want 0", k, level); end
        end
        enable = 1'b0;
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        reset        = 1'b1;
        enable       = 1'b0;
        bus.wr_en    = 1'b0;
        bus.rd_ready = 1'b0;
        $display("[TB] starting buffer_drain_ctrl scenarios");
        test_reset();
        test_drain();
        test_overflow();
        test_full_pop_push();
        test_hold();
        test_reset_in_offer();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired at time %0t", $time);
        $fatal(1, "[TB] watchdog");
    end

endmodule
